// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline encodings: write-back source select, load funct3
// codes and the write-back stage FSM states.
package riscv_pkg;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } wb_state_e;

endpackage

// File: rtl/load_extract.sv
// Combinational sub-word load extraction: picks the addressed lane of an
// aligned load word and sign- or zero-extends it to XLEN.
module load_extract
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] offset,
    input  logic [XLEN-1:0]  rdata,
    output logic [XLEN-1:0]  data
);

    logic [OFF_W-1:0] aligned;
    logic [XLEN-1:0]  shifted;

    always_comb begin
        // Misaligned offsets are rounded down to the access size.
        aligned = offset;
        case (funct3[1:0])
            2'b01:   aligned[0]   = 1'b0;
            2'b10:   aligned[1:0] = 2'b00;
            2'b11:   aligned      = '0;
            default: aligned      = offset;
        endcase

        shifted = rdata >> {aligned, 3'b000};

        data = '0;
        case (funct3)
            F3_LB:   data = XLEN'($signed(shifted[7:0]));
            F3_LH:   data = XLEN'($signed(shifted[15:0]));
            F3_LW:   data = XLEN'($signed(shifted[31:0]));
            F3_LD:   data = (XLEN == 64) ? rdata : '0;
            F3_LBU:  data = XLEN'(shifted[7:0]);
            F3_LHU:  data = XLEN'(shifted[15:0]);
            F3_LWU:  data = XLEN'(shifted[31:0]);
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered RISC-V write-back stage with load-response stall.
// Optional retired-instruction counter enabled by WB_RETIRE_CNT_EN.
module wb_stage_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               regwrite_i,
    input  logic [1:0]         wb_sel_i,
    input  logic [2:0]         funct3_i,
    input  logic [RADDR_W-1:0] rd_i,
    input  logic [XLEN-1:0]    alu_result_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic               dmem_rvalid_i,
    input  logic [XLEN-1:0]    dmem_rdata_i,
    output logic               rf_we_o,
    output logic [RADDR_W-1:0] rf_waddr_o,
    output logic [XLEN-1:0]    rf_wdata_o,
    output logic [63:0]        instret_o
);

    localparam int OFF_W = $clog2(XLEN / 8);

    wb_state_e state, state_next;

    logic               pend_regwrite;
    logic [RADDR_W-1:0] pend_rd;
    logic [2:0]         pend_funct3;
    logic [OFF_W-1:0]   pend_offset;

    logic               accept;
    logic               is_load;
    logic               complete;
    logic               latch_load;
    logic               done_regwrite;
    logic [RADDR_W-1:0] done_rd;
    logic [XLEN-1:0]    done_data;
    logic [XLEN-1:0]    load_data;
    logic [2:0]         ext_funct3;
    logic [OFF_W-1:0]   ext_offset;

    assign ready_o = (state == IDLE);
    assign accept  = valid_i && ready_o;
    assign is_load = (wb_sel_i == WB_MEM);

    // One extractor serves both same-cycle loads and latched waiting loads.
    assign ext_funct3 = (state == WAIT_MEM) ? pend_funct3 : funct3_i;
    assign ext_offset = (state == WAIT_MEM) ? pend_offset : alu_result_i[OFF_W-1:0];

    load_extract #(.XLEN(XLEN)) u_load_extract (
        .funct3 (ext_funct3),
        .offset (ext_offset),
        .rdata  (dmem_rdata_i),
        .data   (load_data)
    );

    always_comb begin
        state_next    = state;
        complete      = 1'b0;
        latch_load    = 1'b0;
        done_rd       = rd_i;
        done_regwrite = regwrite_i;
        done_data     = alu_result_i;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_load && !dmem_rvalid_i) begin
                        latch_load = 1'b1;
                        state_next = WAIT_MEM;
                    end else begin
                        complete = 1'b1;
                        case (wb_sel_i)
                            WB_MEM:  done_data = load_data;
                            WB_PC4:  done_data = pc_i + XLEN'(4);
                            default: done_data = alu_result_i;
                        endcase
                    end
                end
            end
            WAIT_MEM: begin
                if (dmem_rvalid_i) begin
                    complete      = 1'b1;
                    done_rd       = pend_rd;
                    done_regwrite = pend_regwrite;
                    done_data     = load_data;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_regwrite <= 1'b0;
            pend_rd       <= '0;
            pend_funct3   <= '0;
            pend_offset   <= '0;
        end else if (latch_load) begin
            pend_regwrite <= regwrite_i;
            pend_rd       <= rd_i;
            pend_funct3   <= funct3_i;
            pend_offset   <= alu_result_i[OFF_W-1:0];
        end
    end

    // The write port doubles as the bypass source, so x0 always reads back 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else begin
            rf_we_o <= complete && done_regwrite && (done_rd != '0);
            if (complete) begin
                rf_waddr_o <= done_rd;
                rf_wdata_o <= (done_rd == '0) ? '0 : done_data;
            end else begin
                rf_waddr_o <= '0;
                rf_wdata_o <= '0;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (complete) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret_o = instret_q;
`else
    assign instret_o = '0;
`endif

endmodule

// File: doc/wb_stage_pipe.md
# wb_stage_pipe

Parametrised, registered write-back stage for the RISC-V pipeline. Accepts one retiring instruction per cycle from MEM over a valid/ready handshake and selects ALU result, load data or PC+4. Sub-word load data is extracted and extended, with a stall while a load's memory response is outstanding. Drives a registered single register-file write port that also serves as the WB bypass source.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- RADDR_W, 5: register address width.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- valid_i  in  1  MEM presents an instruction.
- ready_o  out  1  stage can accept this cycle.
- regwrite_i  in  1  instruction writes rd.
- wb_sel_i  in  2  0 = ALU, 1 = MEM load, 2 = PC+4 (jal/jalr), 3 = reserved, treated as ALU.
- funct3_i  in  3  load type.
- rd_i  in  RADDR_W  destination register.
- alu_result_i  in  XLEN  ALU result; its low bits are the load byte offset.
- pc_i  in  XLEN  instruction PC.
- dmem_rvalid_i  in  1  load data valid.
- dmem_rdata_i  in  XLEN  aligned load word.
- rf_we_o  out  1  register-file write enable.
- rf_waddr_o  out  RADDR_W  write address.
- rf_wdata_o  out  XLEN  write data.
- instret_o  out  64  retired-instruction count.

## Operation
- FSM states:
  - IDLE: ready_o = 1.
  - WAIT_MEM: ready_o = 0.
- Accept happens when valid_i && ready_o.
- Non-load accept (wb_sel_i ≠ 1): write port registered next cycle. Stay IDLE.
- Load accept with dmem_rvalid_i high in the same cycle: completes like a non-load.
- Load accept without dmem_rvalid_i: latch rd, regwrite, funct3 and offset, then go to WAIT_MEM.
- In WAIT_MEM, the first dmem_rvalid_i completes the load and returns to IDLE. Wait length is unbounded.
- dmem_rvalid_i in IDLE with no load accepted that cycle is ignored.
- Write enable: rf_we_o = regwrite && rd ≠ 0. An x0 destination never asserts we, and rf_wdata_o is forced to 0.
- PC+4 is computed modulo 2^XLEN, so a PC of all-ones+1 wraps.
- Load extraction:
  - Offset = alu_result_i[log2(XLEN/8)-1:0], aligned down to the access size.
  - Selects the lane from dmem_rdata_i.
  - 000 LB, 001 LH, 010 LW, 011 LD: sign-extend.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend.
  - With XLEN=32: LW and LWU return the full word; 011 and 111 return 0.
  - With XLEN=64: 111 returns 0.
- Retirement is the cycle rf_* is presented, whether or not rf_we_o is asserted.

## Timing
- Non-load latency: accept at cycle N, rf_* valid in cycle N+1 for exactly one cycle.
- Load latency: rf_* valid in the cycle after dmem_rvalid_i.
- Throughput: one instruction per cycle while no load is waiting.
- rf_* are registered. rf_we_o is 0 in any cycle with no completion.
- ready_o is combinational from state only, with no path from valid_i.
- Reset values: state IDLE, ready_o 1, rf_we_o 0, rf_waddr_o 0, rf_wdata_o 0, instret_o 0.
- Reset mid-WAIT_MEM drops the pending load with no write. A response arriving after reset is ignored.
- Reset wins over an accept or a completion in the same cycle.

## Configuration
- WB_RETIRE_CNT_EN defined:
  - instret_o is a 64-bit counter, incremented by 1 on every retirement.
  - Wraps from 2^64-1 to 0.
- WB_RETIRE_CNT_EN undefined:
  - instret_o is tied to 0 and no counter flops exist.
  - The port remains present.

## Structure
- Shared package `riscv_pkg` holds:
  - wb_sel encodings: WB_ALU, WB_MEM, WB_PC4.
  - funct3 load encodings: F3_LB … F3_LWU.
- Sub-module `load_extract`: purely combinational. Inputs funct3, offset, rdata; output extended XLEN data. Reusable by a future LSU.
- The FSM and output registers stay in the top module.

## Test plan
- ALU write: valid_i, regwrite 1, rd 5, alu 0x1234_5678 → next cycle rf_we_o 1, waddr 5, wdata 0x1234_5678. instret_o increments 0→1 when WB_RETIRE_CNT_EN is defined, otherwise stays 0.
- jal with rd 0, pc 0x100 → rf_we_o 0, wdata 0, and instret_o still increments. Repeat with rd 1 → wdata 0x104.
- LB, offset 3, rdata 0x80FF_FF12 → wdata 0xFFFF_FF80. LHU, offset 2 → 0x0000_80FF. Both use same-cycle rvalid, so latency is 1.
- Load with rvalid delayed 3 cycles → ready_o 0 for 3 cycles, valid_i held; a write one cycle after rvalid; the next instruction is accepted the cycle after rvalid.
- rst asserted in WAIT_MEM, then rvalid → no write, ready_o 1, instret_o 0.
- XLEN=64: LD, rdata 0x8000_0000_0000_0001 → same value. LWU offset 4 → 0x0000_0000_8000_0000.
